// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the IF/LS single-port RAM arbiter.
// Owner encoding tracks which requester the RAM read data returns to.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam int unsigned RAM_ARB_MAX_STARVE_DEF = 4;
    localparam int unsigned PERF_CNT_W             = 32;
    localparam int unsigned STARVE_CNT_W           = 8;

    // Increment that sticks at the given ceiling.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] val,
        input logic [STARVE_CNT_W-1:0] ceil
    );
        if (val >= ceil) begin
            return ceil;
        end
        return val + STARVE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating starvation counter: counts consecutive IF denials up to MAX_STARVE.
// Clear wins over increment; at_max tells the arbiter IF must win next.
module ram_arb_starve_ctr
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_STARVE = RAM_ARB_MAX_STARVE_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_CNT_W-1:0] MaxCnt = STARVE_CNT_W'(MAX_STARVE);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q, MaxCnt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MaxCnt);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one single-port synchronous RAM between an IF read port and an LS
// read/write port. LS has priority; IF is forced through after MAX_STARVE denials.
// Optional macro RAM_ARB_PERF_EN adds 32-bit grant and conflict counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned MAX_STARVE = RAM_ARB_MAX_STARVE_DEF,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,

    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [AW-1:0]    ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,

`ifdef RAM_ARB_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_if_cnt,
    output logic [PERF_CNT_W-1:0] perf_ls_cnt,
    output logic [PERF_CNT_W-1:0] perf_conflict_cnt,
`endif

    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    logic          starve_at_max;
    logic          if_denied;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    owner_t        rd_owner_q;
    owner_t        rd_owner_d;

    // Grants are masked during reset so nothing reaches the RAM.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!reset) begin
            if (if_req && ls_req) begin
                if_gnt = starve_at_max;
                ls_gnt = ~starve_at_max;
            end else begin
                if_gnt = if_req;
                ls_gnt = ls_req;
            end
        end
    end

    assign if_denied = if_req & ~if_gnt;

    ram_arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve_ctr (
        .clock (clock),
        .reset (reset),
        .inc   (if_denied),
        .clr   (~if_denied),
        .at_max(starve_at_max)
    );

    // Address holds its last value on idle cycles to avoid toggling the RAM pins.
    always_comb begin
        addr_d = addr_q;
        if (if_gnt) begin
            addr_d = if_addr;
        end else if (ls_gnt) begin
            addr_d = ls_addr;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (if_gnt) begin
            rd_owner_d = OWN_IF;
        end else if (ls_gnt && !ls_we) begin
            rd_owner_d = OWN_LS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            addr_q     <= addr_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ram_we    = ls_gnt & ls_we;
    assign ram_addr  = reset ? '0 : addr_d;
    assign ram_wdata = ls_gnt ? ls_wdata : '0;

    // A read in flight when reset rises must not be reported.
    assign if_rvalid = ~reset & (rd_owner_q == OWN_IF);
    assign ls_rvalid = ~reset & (rd_owner_q == OWN_LS);
    assign if_rdata  = ram_rdata;
    assign ls_rdata  = ram_rdata;

`ifdef RAM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_if_q;
    logic [PERF_CNT_W-1:0] perf_if_d;
    logic [PERF_CNT_W-1:0] perf_ls_q;
    logic [PERF_CNT_W-1:0] perf_ls_d;
    logic [PERF_CNT_W-1:0] perf_conf_q;
    logic [PERF_CNT_W-1:0] perf_conf_d;

    always_comb begin
        perf_if_d   = perf_if_q + PERF_CNT_W'(if_gnt);
        perf_ls_d   = perf_ls_q + PERF_CNT_W'(ls_gnt);
        perf_conf_d = perf_conf_q + PERF_CNT_W'(if_req & ls_req);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_if_q   <= '0;
            perf_ls_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_if_q   <= perf_if_d;
            perf_ls_q   <= perf_ls_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_if_cnt       = perf_if_q;
    assign perf_ls_cnt       = perf_ls_q;
    assign perf_conflict_cnt = perf_conf_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a read-return scoreboard.
// Perf counter checks are compiled in when RAM_ARB_PERF_EN is defined.
module tb_ram_arbiter;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned AW         = 10;
    localparam int          MAX_STARVE = 4;

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } ls_txn_t;

    typedef struct {
        logic             is_if;
        logic [WIDTH-1:0] data;
    } sb_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             if_req, if_gnt, if_rvalid;
    logic [AW-1:0]    if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0]    ls_addr;
    logic [WIDTH-1:0] ls_wdata, ls_rdata;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;
`ifdef RAM_ARB_PERF_EN
    logic [31:0]      perf_if_cnt, perf_ls_cnt, perf_conflict_cnt;
`endif

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic             preload;

    logic [AW-1:0]    if_q [$];
    ls_txn_t          ls_q [$];
    sb_t              sb   [$];

    int               n_total = 0;
    int               n_bad   = 0;
    int               exp_starve;
    int               consec;
    logic [AW-1:0]    exp_addr_q;
    logic             last_if_gnt, last_ls_gnt;

    always #5 clock = ~clock;

    ram_arbiter #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_STARVE(MAX_STARVE)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_gnt           (if_gnt),
        .if_rvalid        (if_rvalid),
        .if_rdata         (if_rdata),
        .ls_req           (ls_req),
        .ls_we            (ls_we),
        .ls_addr          (ls_addr),
        .ls_wdata         (ls_wdata),
        .ls_gnt           (ls_gnt),
        .ls_rvalid        (ls_rvalid),
        .ls_rdata         (ls_rdata),
`ifdef RAM_ARB_PERF_EN
        .perf_if_cnt      (perf_if_cnt),
        .perf_ls_cnt      (perf_ls_cnt),
        .perf_conflict_cnt(perf_conflict_cnt),
`endif
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata)
    );

    // Behavioural single-port RAM, 1-cycle read latency.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(16'hA0 + i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: present queue heads, check at negedge against the model, advance.
    task automatic step();
        ls_txn_t       lt;
        sb_t           it;
        logic          e_if, e_ls, both_max;
        logic [AW-1:0] e_addr;
        if_req  = (if_q.size() > 0);
        if_addr = if_req ? if_q[0] : '0;
        ls_req  = (ls_q.size() > 0);
        if (ls_req) begin
            lt = ls_q[0];
            ls_we = lt.we; ls_addr = lt.addr; ls_wdata = lt.wdata;
        end else begin
            ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        end
        @(negedge clock);
        both_max = if_req && (exp_starve == MAX_STARVE);
        e_if   = !reset && if_req && (!ls_req || exp_starve == MAX_STARVE);
        e_ls   = !reset && ls_req && !both_max;
        e_addr = reset ? '0 : (e_if ? if_addr : (e_ls ? ls_addr : exp_addr_q));
        check_eq("if_gnt", 32'(if_gnt), 32'(e_if));
        check_eq("ls_gnt", 32'(ls_gnt), 32'(e_ls));
        check_eq("ram_we", 32'(ram_we), 32'(e_ls && ls_we));
        check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
        check_eq("ram_wdata", 32'(ram_wdata), e_ls ? 32'(ls_wdata) : 32'd0);
        if (!reset && sb.size() > 0) begin
            it = sb.pop_front();
            check_eq("if_rvalid", 32'(if_rvalid), 32'(it.is_if));
            check_eq("ls_rvalid", 32'(ls_rvalid), 32'(!it.is_if));
            if (it.is_if) check_eq("if_rdata", 32'(if_rdata), 32'(it.data));
            else          check_eq("ls_rdata", 32'(ls_rdata), 32'(it.data));
        end else begin
            check_eq("if_rvalid_idle", 32'(if_rvalid), 32'd0);
            check_eq("ls_rvalid_idle", 32'(ls_rvalid), 32'd0);
        end
        if (reset) sb.delete();
        if (if_req && !reset) begin
            consec = if_gnt ? 0 : consec + 1;
            check_eq("starve_bound", 32'(consec <= MAX_STARVE), 32'd1);
        end else begin
            consec = 0;
        end
        if (e_if) begin
            sb.push_back('{is_if: 1'b1, data: exp_mem[if_addr]});
            void'(if_q.pop_front());
        end
        if (e_ls) begin
            if (ls_we) exp_mem[ls_addr] = ls_wdata;
            else sb.push_back('{is_if: 1'b0, data: exp_mem[ls_addr]});
            void'(ls_q.pop_front());
        end
        exp_addr_q = e_addr;
        if (reset || !(if_req && !e_if)) exp_starve = 0;
        else if (exp_starve < MAX_STARVE) exp_starve++;
        last_if_gnt = if_gnt;
        last_ls_gnt = ls_gnt;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        logic busy;
        busy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            busy = (if_q.size() > 0) || (ls_q.size() > 0) || (sb.size() > 0);
            if (!busy) break;
            step();
        end
        busy = (if_q.size() > 0) || (ls_q.size() > 0) || (sb.size() > 0);
        check_eq("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
`ifdef RAM_ARB_PERF_EN
        logic [31:0] s_if, s_ls, s_cf;
`endif
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = WIDTH'(16'hA0 + i);
        preload = 1'b1;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        exp_starve = 0; consec = 0; exp_addr_q = '0;
        last_if_gnt = 1'b0; last_ls_gnt = 1'b0;
        @(posedge clock);
        #1;
        preload = 1'b0;

        // Reset held with both requesting: nothing granted, LS first on release.
        if_q.push_back(10'h040);
        ls_q.push_back('{we: 1'b0, addr: 10'h030, wdata: '0});
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("first_gnt_ls", 32'(last_ls_gnt), 32'd1);
        drain();

        // Back-to-back IF reads of preloaded words.
        for (int i = 0; i < 3; i++) if_q.push_back(AW'(10'h010 + i));
        drain();

        // LS write then read-after-write of the same word.
        ls_q.push_back('{we: 1'b1, addr: 10'h020, wdata: 16'h1234});
        ls_q.push_back('{we: 1'b0, addr: 10'h020, wdata: '0});
        drain();
        check_eq("raw_model", 32'(exp_mem[10'h020]), 32'h1234);

        // Continuous dual requests: LS x4 then IF, repeating.
`ifdef RAM_ARB_PERF_EN
        s_if = perf_if_cnt; s_ls = perf_ls_cnt; s_cf = perf_conflict_cnt;
`endif
        for (int i = 0; i < 12; i++) if_q.push_back(AW'(10'h100 + i));
        for (int i = 0; i < 40; i++) ls_q.push_back('{we: 1'b0, addr: AW'(10'h200 + i), wdata: '0});
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("dual_if_pat", 32'(last_if_gnt), 32'((k % 5) == 4));
        end
`ifdef RAM_ARB_PERF_EN
        check_eq("perf_conflict", perf_conflict_cnt - s_cf, 32'd10);
        check_eq("perf_if", perf_if_cnt - s_if, 32'd2);
        check_eq("perf_ls", perf_ls_cnt - s_ls, 32'd8);
`endif
        if_q.delete();
        ls_q.delete();
        drain();

        // IF read granted, reset next cycle: its data must not be reported.
        if_q.push_back(10'h011);
        step();
        reset = 1'b1;
        step();
        check_eq("rst_inflight_rv", 32'(if_rvalid), 32'd0);
        reset = 1'b0;
        step();

        // Starvation built to 3, then reset: full LS window again before IF.
        if_q.push_back(10'h050);
        for (int i = 0; i < 10; i++) ls_q.push_back('{we: 1'b0, addr: AW'(10'h060 + i), wdata: '0});
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("starve_cleared", 32'(last_if_gnt), 32'(k == 4));
        end
        ls_q.delete();
        drain();

        // Random mixed traffic on a small address window.
        for (int i = 0; i < 60; i++) begin
            if (if_q.size() < 2 && $urandom_range(0, 1) == 1)
                if_q.push_back(AW'(10'h3F0 + $urandom_range(0, 7)));
            if (ls_q.size() < 2 && $urandom_range(0, 1) == 1)
                ls_q.push_back('{we: 1'($urandom_range(0, 1)),
                                 addr: AW'(10'h3F0 + $urandom_range(0, 7)),
                                 wdata: WIDTH'($urandom)});
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares one single-port synchronous RAM (`ram`, 1-cycle read latency) between two requesters.
- Instruction-fetch port (IF): read-only.
- Load/store port (LS): read/write.
- Sits between the core front end / LSU and the `ram` instance, for configurations without `ram_dp`.
- LS has fixed priority, bounded by a starvation counter that guarantees IF progress.

Parameters:
- WIDTH, 16, data width; must match the attached `ram`.
- DEPTH, 1024, RAM words; address width AW = $clog2(DEPTH).
- MAX_STARVE, 4, consecutive cycles IF may be denied before it is forced to win; range 1..255.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  IF read request, held until granted
- if_addr  in  AW  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid, one cycle after if_gnt
- if_rdata  out  WIDTH  IF read data
- ls_req  in  1  LS request, held until granted
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  AW  LS word address
- ls_wdata  in  WIDTH  LS write data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  LS read data valid, one cycle after a read grant
- ls_rdata  out  WIDTH  LS read data
- ram_we  out  1  to ram.write_en
- ram_addr  out  AW  to ram.addr
- ram_wdata  out  WIDTH  to ram.data_i
- ram_rdata  in  WIDTH  from ram.data_o

Behaviour:
- Clock port is `clock`; reset port is `reset`, synchronous, active-high. Already decided.
- While reset is high:
  - if_gnt, ls_gnt, ram_we, if_rvalid, ls_rvalid = 0.
  - ram_addr = 0, ram_wdata = 0.
  - starve_cnt = 0, rd_owner = OWN_NONE.
- Grant logic is combinational from the current req and state; one RAM access per cycle; back-to-back grants allowed every cycle.
- Arbitration each cycle:
  - Only one req → that requester is granted.
  - Both req and starve_cnt < MAX_STARVE → LS wins.
  - Both req and starve_cnt == MAX_STARVE → IF wins.
- starve_cnt (registered):
  - Increments when if_req=1 and if_gnt=0, saturating at MAX_STARVE.
  - Clears to 0 on any cycle with if_gnt=1 or if_req=0.
- Granted requester drives ram_addr.
  - ram_we = ls_gnt & ls_we; ram_wdata = ls_wdata when LS is granted, else 0.
  - No grant: ram_we = 0, ram_addr holds its previous registered value (avoids needless toggling).
- rd_owner register, updated every cycle:
  - OWN_IF after an IF grant.
  - OWN_LS after an LS read grant.
  - OWN_NONE after an LS write or no grant.
- Read return, the cycle after the grant:
  - if_rvalid = (rd_owner == OWN_IF); ls_rvalid = (rd_owner == OWN_LS).
  - if_rdata and ls_rdata are both wired to ram_rdata; rvalid qualifies which is meaningful.
- Writes produce no rvalid. An LS write is complete at grant.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first at the next edge; no bypass needed).
- Reset asserted while a read is in flight: rd_owner clears, and no rvalid is emitted on the following cycle.
- A requester must not change addr, we or wdata while req=1 and gnt=0. Violation is a requester bug; the arbiter samples the current values.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_cnt, perf_ls_cnt, perf_conflict_cnt (each 32 bits).
  - perf_if_cnt and perf_ls_cnt count grants to the respective port.
  - perf_conflict_cnt counts cycles with if_req & ls_req.
  - All three are synchronous-reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ram_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_LS}.
  - RAM_ARB_MAX_STARVE_DEF = 4.
  - PERF_CNT_W = 32.
- Sub-module ram_arb_starve_ctr: saturating counter with inputs inc, clr, and output at_max; parameterised by MAX_STARVE.
- Grant mux and rd_owner stay in the top level.

Test Plan:
- reset=1 for 3 cycles with if_req=ls_req=1 → all gnt, rvalid and ram_we are 0 throughout; first grant in the cycle reset falls, to LS.
- IF-only reads of addrs 0x010, 0x011, 0x012 on consecutive cycles (RAM preloaded with 0xA0+addr) → if_gnt=1 every cycle; if_rvalid in cycles 2-4 with data 0xB0, 0xB1, 0xB2.
- LS write 0x1234 to 0x020, then LS read 0x020 next cycle → ram_we=1 on cycle 1, no rvalid for the write, ls_rvalid with 0x1234 on cycle 3.
- if_req and ls_req held continuously, MAX_STARVE=4 → grant sequence LS, LS, LS, LS, IF, repeating; no more than 4 consecutive IF denials.
- IF granted, reset pulsed the next cycle → if_rvalid stays 0; starve_cnt=0 afterward.
- With RAM_ARB_PERF_EN, 10 cycles of dual requests → perf_conflict_cnt=10; perf_ls_cnt + perf_if_cnt = 10, with perf_if_cnt=2.
